glitch_pulse_gen: RTL and testbench

- Upstream timing stage for glitch_core; produces the `en` strobe it consumes.
- Armed by the host with a delay, width, gap and repeat count.
- On a target trigger edge, emits a train of cycle-exact enable pulses on `en_out`, which drives glitch_core `en`.
- Reports `busy` status and a one-cycle `done`.

---
 rtl/glitch_pulse_gen_pkg.sv | 23 ++
 rtl/glitch_edge_det.sv | 49 ++++
 rtl/glitch_pulse_gen.sv | 166 ++++++++++++++++
 tb/tb_glitch_pulse_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_pulse_gen_pkg
//  Brief    : Shared state encoding and default widths for the glitch
//             timing stage and its trigger front end.
//  Revision : 1.0  initial release
// ============================================================================
package glitch_pulse_gen_pkg;

    localparam int c_CNT_W_DEFAULT = 16;
    localparam int c_REP_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/glitch_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_edge_det
//  Brief    : Rising-edge detector for the target trigger line. With
//             GLITCH_TRIG_SYNC_EN defined, the trigger first passes through a
//             2-flop synchroniser (2 cycles of fixed extra latency).
//  Revision : 1.0  initial release
// ============================================================================
module glitch_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_i,
    output logic trig_edge_o
);

    logic trig_s;
    logic trig_s_d_q;

`ifdef GLITCH_TRIG_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser for an asynchronous trigger source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], trig_i};
        end
    end

    assign trig_s = sync_q[1];
`else
    // Trigger is already synchronous to clk: use it directly
    assign trig_s = trig_i;
`endif

    // One-cycle history of the (possibly synchronised) trigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s_d_q <= 1'b0;
        end else begin
            trig_s_d_q <= trig_s;
        end
    end

    assign trig_edge_o = trig_s & ~trig_s_d_q;

endmodule
`default_nettype wire

// File: rtl/glitch_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_pulse_gen
//  Brief    : Armed, triggered generator of a cycle-exact enable pulse train
//             (delay, width, gap, repeat) driving glitch_core en.
//             Optional macro GLITCH_TRIG_SYNC_EN adds a trigger synchroniser.
//  Revision : 1.0  initial release
// ============================================================================
module glitch_pulse_gen
    import glitch_pulse_gen_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT,
    parameter int REP_W = c_REP_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [REP_W-1:0] repeat_n,
    output logic             en_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] c_REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] pulses_q, pulses_d;
    logic             en_q, en_d;

    // Latched configuration; width/gap/repeat held already clamped to >= 1
    logic [CNT_W-1:0] delay_q, width_q, gap_q;
    logic [REP_W-1:0] rep_q;

    logic trig_edge;
    logic cfg_load;

    glitch_edge_det u_edge_det (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_i      (trigger),
        .trig_edge_o (trig_edge)
    );

    // Config is only accepted from IDLE; abort in the same cycle wins
    assign cfg_load = (state_q == ST_IDLE) && arm && !abort;

    // Capture the configuration on a successful arm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q <= '0;
            width_q <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
        end else if (cfg_load) begin
            delay_q <= delay;
            width_q <= (width == '0)    ? c_CNT_ONE : width;
            gap_q   <= (gap == '0)      ? c_CNT_ONE : gap;
            rep_q   <= (repeat_n == '0) ? c_REP_ONE : repeat_n;
        end
    end

    // State, counters and the en_out flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pulses_q <= '0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulses_q <= pulses_d;
            en_q     <= en_d;
        end
    end

    // Next-state logic; en_d is computed so en_out changes on the same edge
    // as the state transition that starts or ends a pulse
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulses_d = pulses_q;
        en_d     = en_q;

        if (abort) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    en_d = 1'b0;
                    if (arm) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_edge) begin
                        pulses_d = rep_q;
                        if (delay_q == '0) begin
                            state_d = ST_PULSE;
                            en_d    = 1'b1;
                            cnt_d   = width_q - c_CNT_ONE;
                        end else begin
                            state_d = ST_DELAY;
                            cnt_d   = delay_q - c_CNT_ONE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_PULSE;
                        en_d    = 1'b1;
                        cnt_d   = width_q - c_CNT_ONE;
                    end else begin
                        cnt_d = cnt_q - c_CNT_ONE;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        en_d     = 1'b0;
                        pulses_d = pulses_q - c_REP_ONE;
                        if (pulses_q == c_REP_ONE) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = gap_q - c_CNT_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - c_CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_PULSE;
                        en_d    = 1'b1;
                        cnt_d   = width_q - c_CNT_ONE;
                    end else begin
                        cnt_d = cnt_q - c_CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                end
            endcase
        end
    end

    // en_out comes straight from a flop since it gates a clock downstream
    assign en_out = en_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_glitch_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glitch_pulse_gen
//  Brief    : Self-checking bench for glitch_pulse_gen with a timeline-based
//             reference model (pulse k occupies [S+k*(w+g), S+k*(w+g)+w)).
//             Honours GLITCH_TRIG_SYNC_EN for the trigger latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_glitch_pulse_gen;

`ifdef GLITCH_TRIG_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic        abort;
    logic        trigger;
    logic [15:0] delay;
    logic [15:0] width;
    logic [15:0] gap;
    logic [7:0]  repeat_n;
    logic        en_out;
    logic        busy;
    logic        done;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    glitch_pulse_gen #(
        .CNT_W (16),
        .REP_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .abort    (abort),
        .trigger  (trigger),
        .delay    (delay),
        .width    (width),
        .gap      (gap),
        .repeat_n (repeat_n),
        .en_out   (en_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Count active edges; sampled on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: expected en_out after edge n for a train starting at edge s
    function automatic bit m_en(input int n, input int s, input int we, input int ge, input int re);
        int rel;
        int p;
        rel = n - s;
        p   = we + ge;
        if (rel < 0)        return 1'b0;
        if (rel / p >= re)  return 1'b0;
        return (rel % p) < we;
    endfunction

    task automatic scramble_cfg();
        delay    = 16'($urandom);
        width    = 16'($urandom);
        gap      = 16'($urandom);
        repeat_n = 8'($urandom);
    endtask

    task automatic idle_checks(input string tag, input int n, input bit toggle_trig);
        repeat (n) begin
            @(negedge clk);
            check({tag, "_en"},   en_out, 0);
            check({tag, "_busy"}, busy,   0);
            check({tag, "_done"}, done,   0);
            if (toggle_trig) trigger = 1'($urandom_range(0, 1));
        end
        trigger = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // One armed train. ab_rel >= 0 aborts at edge S+ab_rel (never before the
    // first observed edge). noise drives retriggers and re-arms mid-train.
    task automatic run_train(input int d, input int w, input int g, input int r,
                             input int ab_rel, input bit noise);
        int we, ge, re, t, s, e, a, last, k, n;
        bit x_en, x_done, x_busy;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        re = (r == 0) ? 1 : r;

        @(negedge clk);
        arm = 1'b1; abort = 1'b0;
        delay = d[15:0]; width = w[15:0]; gap = g[15:0]; repeat_n = r[7:0];
        @(negedge clk);
        arm = 1'b0;
        scramble_cfg();
        check("arm_busy", busy, 1);
        check("arm_en", en_out, 0);
        k = $urandom_range(0, 3);
        repeat (k) begin
            @(negedge clk);
            check("armed_en", en_out, 0);
        end

        trigger = 1'b1;
        t = cyc + 1;
        s = t + c_LAT + d;
        e = s + re * we + (re - 1) * ge;
        a = (ab_rel >= 0) ? s + ab_rel : (1 << 30);
        if (a < t + 1) a = t + 1;
        last = (a <= e) ? a + 1 : e + 2;

        do begin
            @(negedge clk);
            n = cyc;
            if (n >= a) begin
                x_en = 0; x_done = 0; x_busy = 0;
            end else begin
                x_en   = m_en(n, s, we, ge, re);
                x_done = (n == e);
                x_busy = (n <= e);
            end
            check("train_en",   en_out, x_en);
            check("train_done", done,   x_done);
            check("train_busy", busy,   x_busy);
            abort = (n == a - 1);
            if (noise && n >= t) trigger = 1'($urandom_range(0, 1));
            arm = noise && (n + 1 < a) && (n + 1 <= e) && ($urandom_range(0, 3) == 0);
            if (arm) scramble_cfg();
        end while (n < last);

        abort = 1'b0; arm = 1'b0; trigger = 1'b0;
        idle_checks("post", 6, 1'b1);
    endtask

    // Asynchronous reset at edge S+rel of a train (w=2, g=4, r=3, d=1)
    task automatic reset_mid(input int rel);
        int t, s;
        @(negedge clk);
        arm = 1'b1; delay = 16'd1; width = 16'd2; gap = 16'd4; repeat_n = 8'd3;
        @(negedge clk);
        arm = 1'b0;
        trigger = 1'b1;
        t = cyc + 1;
        s = t + c_LAT + 1;
        while (cyc < s + rel) @(negedge clk);
        check("pre_rst_en", en_out, m_en(cyc, s, 2, 4, 3));
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_en",   en_out, 0);
        check("async_rst_busy", busy,   0);
        check("async_rst_done", done,   0);
        trigger = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        trigger = 1'b1;
        idle_checks("after_rst", 6, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
        delay = '0; width = '0; gap = '0; repeat_n = '0;
        repeat (3) @(negedge clk);
        check("reset_en",   en_out, 0);
        check("reset_busy", busy,   0);
        check("reset_done", done,   0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Trigger while IDLE must not start anything
        trigger = 1'b1;
        idle_checks("idle_trig", 4, 1'b1);

        run_train(5, 3, 0, 2, -1, 1'b0);   // basic train
        run_train(0, 0, 3, 0, -1, 1'b0);   // zero delay, degenerate width/repeat
        run_train(5, 3, 0, 2, -1, 1'b1);   // retrigger and re-arm mid-train
        run_train(2, 10, 1, 3, 2, 1'b0);   // abort on 2nd pulse cycle
        run_train(3, 1, 1, 4, -1, 1'b0);   // minimum width and gap

        // Arm and abort together: abort wins, stays IDLE
        @(negedge clk);
        arm = 1'b1; abort = 1'b1; delay = 16'd0; width = 16'd1; repeat_n = 8'd1;
        @(negedge clk);
        arm = 1'b0; abort = 1'b0;
        trigger = 1'b1;
        idle_checks("arm_abort", 5, 1'b0);

        reset_mid(3);   // mid-GAP
        reset_mid(0);   // first PULSE cycle

        for (int i = 0; i < 25; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            run_train($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3),
                      $urandom_range(0, 3), ab, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
